// File: rtl/sensor_debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
// Channel FSM encoding plus default sync depth and stability count.
package sensor_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } deb_state_t;

    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_DEBOUNCE_CNT = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit conditioner: synchroniser, stability counter, FSM.
// Registered level and edge pulses; no combinational input path.
module debounce_channel
    import sensor_debounce_pkg::*;
#(
    parameter  int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter  int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    localparam int CNT_W        = $clog2(DEBOUNCE_CNT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam bit               INSTANT  = (DEBOUNCE_CNT == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    deb_state_t             state;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // A single-cycle count commits on the entry edge itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STABLE_LO;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                STABLE_LO: begin
                    if (sync) begin
                        if (INSTANT) begin
                            state <= STABLE_HI;
                            clean <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            state <= WAIT_HI;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                WAIT_HI: begin
                    if (!sync) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HI;
                        clean <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!sync) begin
                        if (INSTANT) begin
                            state <= STABLE_LO;
                            clean <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            state <= WAIT_LO;
                            cnt   <= CNT_ONE;
                        end
                    end
                end
                WAIT_LO: begin
                    if (sync) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        clean <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sensor_debounce.sv
// Multi-channel switch conditioner feeding the traffic-light FSM.
// One independent debounce_channel per input bit.
module sensor_debounce
    import sensor_debounce_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("sensor_debounce: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CNT < 1) begin : g_bad_cnt
        $error("sensor_debounce: DEBOUNCE_CNT must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CNT(DEBOUNCE_CNT)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_in[i]),
            .clean(clean_out[i]),
            .rise (rise_pulse[i]),
            .fall (fall_pulse[i])
        );
    end

endmodule
